// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into a registered, word-aligned memory
// request, stalls the core until the memory answers, and extends the returned load data.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access in flight; legal aligned core request is captured
// BUSY  | memory request held stable, waiting for mem_ready_i or timeout
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       cap_size;
    logic [1:0]       cap_off;

    logic             size_legal;
    logic             aligned;
    logic             req_ok;
    logic             req_bad;
    logic             timeout;
    logic [3:0]       be_next;
    logic [31:0]      wd_next;

    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  size,
                                                 input logic [1:0]  off);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        byte_v = word[{off, 3'b000} +: 8];
        half_v = off[1] ? word[31:16] : word[15:0];
        res    = 32'd0;
        case (size)
            SZ_B:    res = {{24{byte_v[7]}}, byte_v};
            SZ_BU:   res = {24'd0, byte_v};
            SZ_H:    res = {{16{half_v[15]}}, half_v};
            SZ_HU:   res = {16'd0, half_v};
            SZ_W:    res = word;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    always_comb begin
        size_legal = 1'b0;
        aligned    = 1'b0;
        be_next    = 4'b0000;
        wd_next    = 32'd0;
        case (core_size_i)
            SZ_B, SZ_BU: begin
                size_legal = 1'b1;
                aligned    = 1'b1;
                be_next    = 4'b0001 << core_addr_i[1:0];
                wd_next    = {4{core_wd_i[7:0]}};
            end
            SZ_H, SZ_HU: begin
                size_legal = 1'b1;
                aligned    = ~core_addr_i[0];
                be_next    = 4'b0011 << core_addr_i[1:0];
                wd_next    = {2{core_wd_i[15:0]}};
            end
            SZ_W: begin
                size_legal = 1'b1;
                aligned    = (core_addr_i[1:0] == 2'b00);
                be_next    = 4'b1111;
                wd_next    = core_wd_i;
            end
            default: begin
                size_legal = 1'b0;
                aligned    = 1'b0;
            end
        endcase
    end

    assign req_ok  = core_req_i & size_legal & aligned;
    assign req_bad = core_req_i & ~(size_legal & aligned);
    assign timeout = (state == BUSY) && (cnt == CNT_LAST);

    // Core inputs are only meaningful in IDLE; in BUSY the core is frozen on a legal request.
    assign misalign_o = (state == IDLE) & req_bad;

    always_comb begin
        core_stall_o = 1'b0;
        if (!rst_i) begin
            if (state == IDLE) begin
                core_stall_o = req_ok;
            end else begin
                core_stall_o = ~mem_ready_i & ~timeout;
            end
        end
    end

    always_comb begin
        core_rd_o = 32'd0;
        if ((state == BUSY) && mem_ready_i && !mem_we_o) begin
            core_rd_o = extract_load(mem_rd_i, cap_size, cap_off);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_size   <= 3'd0;
            cap_off    <= 2'd0;
            bus_err_o  <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= 4'b0000;
            mem_addr_o <= 32'd0;
            mem_wd_o   <= 32'd0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_ok) begin
                        state      <= BUSY;
                        cap_size   <= core_size_i;
                        cap_off    <= core_addr_i[1:0];
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= core_we_i;
                        mem_be_o   <= be_next;
                        mem_addr_o <= {core_addr_i[31:2], 2'b00};
                        mem_wd_o   <= wd_next;
                    end
                end
                BUSY: begin
                    if (mem_ready_i || timeout) begin
                        // A ready arriving on the timeout cycle still completes cleanly.
                        state      <= IDLE;
                        cnt        <= '0;
                        bus_err_o  <= ~mem_ready_i;
                        mem_req_o  <= 1'b0;
                        mem_we_o   <= 1'b0;
                        mem_be_o   <= 4'b0000;
                        mem_addr_o <= 32'd0;
                        mem_wd_o   <= 32'd0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit built with a 4-cycle memory timeout.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int vectors = 0;
    int miscompares = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Drives one access from posedge+1, answers with ready in BUSY cycle wait_n+1,
    // and returns what was observed at each negedge. Returns at posedge+1 after completion.
    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdw, input int wait_n,
                          output int stalls, output int busy_cycles, output logic [31:0] rd,
                          output logic [31:0] maddr, output logic [3:0] be,
                          output logic [31:0] mwd, output logic mwe, output logic mis,
                          output logic done);
        int b;
        b = 0; stalls = 0; busy_cycles = 0; rd = '0; maddr = '0; be = '0;
        mwd = '0; mwe = 1'b0; mis = 1'b0; done = 1'b0;
        core_req_i = 1'b1; core_we_i = we; core_size_i = sz; core_addr_i = addr;
        core_wd_i = wd; mem_rd_i = rdw; mem_ready_i = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk_i);
            if (c == 0) mis = misalign_o;
            if (mem_req_o) begin
                busy_cycles++;
                maddr = mem_addr_o; be = mem_be_o; mwd = mem_wd_o; mwe = mem_we_o;
            end
            if (core_stall_o) stalls++;
            else begin
                rd = core_rd_o;
                done = 1'b1;
            end
            @(posedge clk_i); #1;
            if (done) begin
                core_req_i = 1'b0; mem_ready_i = 1'b0;
            end else if (mem_req_o) begin
                b++;
                mem_ready_i = (b == wait_n + 1);
            end
        end
        core_req_i = 1'b0;
        mem_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
        core_addr_i = '0; core_wd_i = '0; mem_rd_i = '0; mem_ready_i = 1'b0;
        #2;
        vectors++;
        if ({mem_req_o, mem_we_o, mem_be_o} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_mem_ctrl: got req/we/be %b expected 000000", {mem_req_o, mem_we_o, mem_be_o});
        end
        vectors++;
        if ({mem_addr_o, mem_wd_o} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_mem_data: got addr %h wd %h expected 0", mem_addr_o, mem_wd_o);
        end
        vectors++;
        if ({bus_err_o, core_stall_o, misalign_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got err/stall/mis %b expected 000", {bus_err_o, core_stall_o, misalign_o});
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_load_word();
        int st, bc; logic [31:0] rd, ma, mw; logic [3:0] be; logic we, mis, dn;
        access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (dn !== 1'b1 || st !== 2) begin
            miscompares++;
            $display("FAIL lw_stalls: got done %0b stalls %0d expected done 1 stalls 2", dn, st);
        end
        vectors++;
        if (ma !== 32'h100 || be !== 4'b1111 || we !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_mem: got addr %h be %b we %b expected 00000100 1111 0", ma, be, we);
        end
        vectors++;
        if (rd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL lw_data: got %h expected deadbeef", rd);
        end
        vectors++;
        if (bus_err_o !== 1'b0 || mem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_after: got err %b req %b expected 0 0", bus_err_o, mem_req_o);
        end
    endtask

    task automatic test_load_ext();
        int st, bc; logic [31:0] rd, ma, mw; logic [3:0] be; logic we, mis, dn;
        access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (rd !== 32'hFFFFFF80 || st !== 1) begin
            miscompares++;
            $display("FAIL lb_sign: got %h stalls %0d expected ffffff80 stalls 1", rd, st);
        end
        vectors++;
        if (be !== 4'b1000 || ma !== 32'h100) begin
            miscompares++;
            $display("FAIL lb_be: got be %b addr %h expected 1000 00000100", be, ma);
        end
        access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (rd !== 32'h00000080) begin
            miscompares++;
            $display("FAIL lbu_zero: got %h expected 00000080", rd);
        end
        access(1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF_0000, 0, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (rd !== 32'h000080FF || be !== 4'b1100) begin
            miscompares++;
            $display("FAIL lhu_zero: got %h be %b expected 000080ff 1100", rd, be);
        end
        access(1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF_0000, 2, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (rd !== 32'hFFFF80FF || st !== 3) begin
            miscompares++;
            $display("FAIL lh_sign: got %h stalls %0d expected ffff80ff stalls 3", rd, st);
        end
        access(1'b0, 3'd4, 32'h101, 32'h0, 32'h80FF_0000, 0, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (rd !== 32'h00000000 || be !== 4'b0010) begin
            miscompares++;
            $display("FAIL lbu_byte1: got %h be %b expected 00000000 0010", rd, be);
        end
    endtask

    task automatic test_store();
        int st, bc; logic [31:0] rd, ma, mw; logic [3:0] be; logic we, mis, dn;
        access(1'b1, 3'd1, 32'h206, 32'h1234ABCD, 32'hFFFF_FFFF, 0, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (we !== 1'b1 || be !== 4'b1100 || ma !== 32'h204) begin
            miscompares++;
            $display("FAIL sh_ctrl: got we %b be %b addr %h expected 1 1100 00000204", we, be, ma);
        end
        vectors++;
        if (mw !== 32'hABCDABCD || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL sh_data: got wd %h rd %h expected abcdabcd 00000000", mw, rd);
        end
        access(1'b1, 3'd0, 32'h201, 32'h0000_005A, 32'h0, 0, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (mw !== 32'h5A5A5A5A || be !== 4'b0010 || ma !== 32'h200) begin
            miscompares++;
            $display("FAIL sb: got wd %h be %b addr %h expected 5a5a5a5a 0010 00000200", mw, be, ma);
        end
    endtask

    task automatic test_misalign();
        int st, bc; logic [31:0] rd, ma, mw; logic [3:0] be; logic we, mis, dn;
        logic [2:0]  sz [3];
        logic [31:0] ad [3];
        sz[0] = 3'd2; ad[0] = 32'h101;
        sz[1] = 3'd3; ad[1] = 32'h100;
        sz[2] = 3'd5; ad[2] = 32'h103;
        for (int i = 0; i < 3; i++) begin
            access(1'b0, sz[i], ad[i], 32'h0, 32'hDEADBEEF, 0, st, bc, rd, ma, be, mw, we, mis, dn);
            vectors++;
            if (mis !== 1'b1 || st !== 0 || bc !== 0 || rd !== 32'h0) begin
                miscompares++;
                $display("FAIL misalign_%0d: got mis %b stalls %0d reqs %0d rd %h expected 1 0 0 0",
                         i, mis, st, bc, rd);
            end
        end
    endtask

    task automatic test_timeout();
        int st, bc; logic [31:0] rd, ma, mw; logic [3:0] be; logic we, mis, dn;
        access(1'b0, 3'd2, 32'h40, 32'h0, 32'h12345678, 100, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (dn !== 1'b1 || bc !== 4 || st !== 4 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL to_abort: got done %b busy %0d stalls %0d rd %h expected 1 4 4 0", dn, bc, st, rd);
        end
        vectors++;
        if (bus_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL to_err_pulse: got %b expected 1", bus_err_o);
        end
        @(posedge clk_i); #1;
        vectors++;
        if (bus_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL to_err_clear: got %b expected 0", bus_err_o);
        end
        access(1'b0, 3'd2, 32'h40, 32'h0, 32'h12345678, 3, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (bc !== 4 || st !== 4 || rd !== 32'h12345678 || bus_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL to_ready_last: got busy %0d stalls %0d rd %h err %b expected 4 4 12345678 0",
                     bc, st, rd, bus_err_o);
        end
    endtask

    task automatic test_back_to_back();
        int st, bc; logic [31:0] rd, ma, mw; logic [3:0] be; logic we, mis, dn;
        access(1'b0, 3'd0, 32'h0, 32'h0, 32'h0000_007F, 0, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (rd !== 32'h0000007F) begin
            miscompares++;
            $display("FAIL b2b_lb: got %h expected 0000007f", rd);
        end
        access(1'b1, 3'd2, 32'h4, 32'hCAFEF00D, 32'h0, 2, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (st !== 3 || mw !== 32'hCAFEF00D || be !== 4'b1111 || ma !== 32'h4 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL b2b_sw: got stalls %0d wd %h be %b addr %h rd %h expected 3 cafef00d 1111 00000004 0",
                     st, mw, be, ma, rd);
        end
        access(1'b0, 3'd1, 32'h2, 32'h0, 32'h8001_1234, 0, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (rd !== 32'hFFFF8001) begin
            miscompares++;
            $display("FAIL b2b_lh: got %h expected ffff8001", rd);
        end
    endtask

    task automatic test_async_reset();
        int st, bc; logic [31:0] rd, ma, mw; logic [3:0] be; logic we, mis, dn;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h300;
        mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        vectors++;
        if (mem_req_o !== 1'b1 || core_stall_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ar_busy: got req %b stall %b expected 1 1", mem_req_o, core_stall_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        vectors++;
        if (mem_req_o !== 1'b0 || core_stall_o !== 1'b0 || bus_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ar_drop: got req %b stall %b err %b expected 0 0 0", mem_req_o, core_stall_o, bus_err_o);
        end
        core_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        access(1'b0, 3'd2, 32'h300, 32'h0, 32'h0BADF00D, 0, st, bc, rd, ma, be, mw, we, mis, dn);
        vectors++;
        if (st !== 1 || rd !== 32'h0BADF00D || ma !== 32'h300 || bus_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ar_recover: got stalls %0d rd %h addr %h err %b expected 1 0badf00d 00000300 0",
                     st, rd, ma, bus_err_o);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_ext();
        test_store();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
